seg7_scan_monitor: RTL and testbench

- Passive reader for the four-digit multiplexed 7-segment interface that our timer/counter labs drive on DIGIT/DISPLAY.
- Samples the scanned anode/segment lines and debounces each scan dwell.
- Decodes the segment patterns back into BCD and publishes a complete, atomically updated 4-digit frame.
- Used in benches and on-board self-check to verify display content without reading the segment waveforms by eye.

---
 rtl/seg7_pkg.sv | 55 +++++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_monitor.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_monitor.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan monitor: segment patterns,
// decoded code values, digit-select encodings and slot helpers.
package seg7_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decoded code values outside the BCD range
    localparam logic [3:0] CODE_BLANK   = 4'hA;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    // Anode selects, active-low one-hot
    localparam logic [3:0] DIG0_SEL = 4'b1110;
    localparam logic [3:0] DIG1_SEL = 4'b1101;
    localparam logic [3:0] DIG2_SEL = 4'b1011;
    localparam logic [3:0] DIG3_SEL = 4'b0111;

    typedef enum logic {
        ST_LOST  = 1'b0,
        ST_TRACK = 1'b1
    } scan_state_t;

    // True when exactly one anode line is driven low
    function automatic logic sel_is_valid(input logic [3:0] sel);
        logic ok;
        case (sel)
            DIG0_SEL, DIG1_SEL, DIG2_SEL, DIG3_SEL: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Slot index of a valid anode select (0 for anything else)
    function automatic logic [1:0] sel_to_slot(input logic [3:0] sel);
        logic [1:0] slot;
        case (sel)
            DIG1_SEL: slot = 2'd1;
            DIG2_SEL: slot = 2'd2;
            DIG3_SEL: slot = 2'd3;
            default:  slot = 2'd0;
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern decoder: maps an active-low {g..a}
// pattern back to its BCD digit, blank, or an invalid marker.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] display,
    output logic [3:0] code
);

    // Pattern lookup; anything not in the table is flagged invalid
    always_comb begin
        code = CODE_INVALID;
        case (display)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Passive monitor for a 4-digit multiplexed 7-segment display.
// Each scan dwell is debounced (STABLE_CYCLES identical samples, min 2),
// decoded and stored in a shadow slot; once all four slots have been seen
// the frame is published atomically on bcd_out with a frame_valid pulse.
// scan_lost flags TIMEOUT_CYCLES without any committed dwell.
module seg7_scan_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 500000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  DIGIT,
    input  logic [6:0]  DISPLAY,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        scan_lost
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [10:0]      sample;
    logic [10:0]      s_q;
    logic             sample_stable;
    logic [CNT_W-1:0] stab_cnt;
    logic             dwell_done;
    logic             commit;
    logic [1:0]       commit_slot;
    logic [3:0]       commit_code;
    logic [3:0]       slot_bit;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout_hit;
    scan_state_t      state;
    scan_state_t      state_next;
    logic [3:0]       shadow [4];
    logic [3:0]       seen;
    logic [3:0]       seen_next;
    logic             frame_pend;
    logic             frame_done;
    logic             shadow_has_err;

    assign sample = {DIGIT, DISPLAY};

    // A sample continues the current dwell only if it repeats the previous
    // one and selects exactly one digit.
    assign sample_stable = (sample == s_q) && sel_is_valid(DIGIT);

    // The dwell in s_q has been stable long enough and has not been taken yet
    assign commit      = (stab_cnt == CNT_MAX) && !dwell_done;
    assign commit_slot = sel_to_slot(s_q[10:7]);
    assign slot_bit    = 4'b0001 << commit_slot;

    seg7_pattern_decode u_decode (
        .display (s_q[6:0]),
        .code    (commit_code)
    );

    // A commit on the same edge as the timeout keeps the scan alive
    assign timeout_hit = (state == ST_TRACK) && (to_cnt == TO_MAX) && !commit;

    // seen is cleared on the publish edge, so a commit there starts a new frame
    assign seen_next  = (frame_pend ? 4'b0000 : seen) | (commit ? slot_bit : 4'b0000);
    assign frame_done = commit && (seen_next == 4'b1111);

    assign shadow_has_err = (shadow[0] == CODE_INVALID) || (shadow[1] == CODE_INVALID) ||
                            (shadow[2] == CODE_INVALID) || (shadow[3] == CODE_INVALID);

    assign scan_lost = (state == ST_LOST);

    // Register the raw anode/segment lines every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= '1;
        end else begin
            s_q <= sample;
        end
    end

    // Dwell debounce: saturating stability count plus a one-commit-per-dwell latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stab_cnt   <= '0;
            dwell_done <= 1'b0;
        end else if (sample_stable) begin
            if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            if (commit) begin
                dwell_done <= 1'b1;
            end
        end else begin
            stab_cnt   <= '0;
            dwell_done <= 1'b0;
        end
    end

    // Cycles since the last commit; only meaningful while tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (commit || timeout_hit || (state == ST_LOST)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Scan-tracking state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOST;
        end else begin
            state <= state_next;
        end
    end

    // Next state: first commit locks on, a commit-free timeout drops lock
    always_comb begin
        state_next = state;
        case (state)
            ST_LOST:  if (commit)      state_next = ST_TRACK;
            ST_TRACK: if (timeout_hit) state_next = ST_LOST;
            default:                   state_next = ST_LOST;
        endcase
    end

    // Shadow slots, seen mask and the publish request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= CODE_BLANK;
            end
            seen       <= 4'b0000;
            frame_pend <= 1'b0;
        end else if (timeout_hit) begin
            seen       <= 4'b0000;
            frame_pend <= 1'b0;
        end else begin
            if (commit) begin
                shadow[commit_slot] <= commit_code;
            end
            seen       <= frame_done ? 4'b0000 : seen_next;
            frame_pend <= frame_done;
        end
    end

    // Publish the complete frame one edge after the last slot is committed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_out     <= {4{CODE_BLANK}};
            seg_err     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_pend;
            if (frame_pend) begin
                bcd_out <= {shadow[3], shadow[2], shadow[1], shadow[0]};
                seg_err <= shadow_has_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Testbench for seg7_scan_monitor: directed scenarios plus a randomized
// scan, all checked against a dwell/frame reference model.
module tb_seg7_scan_monitor;

    localparam int N = 4;
    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  DIGIT = 4'b1111;
    logic [6:0]  DISPLAY = 7'b1111111;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        seg_err;
    logic        scan_lost;

    seg7_scan_monitor #(.STABLE_CYCLES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .DIGIT       (DIGIT),
        .DISPLAY     (DISPLAY),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .scan_lost   (scan_lost)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    cyc_err = 0;
    int    pulses = 0;
    int    m_pulses = 0;
    string first_diff = "";

    // Reference model state
    int          m_run;
    bit          m_done;
    logic [3:0]  m_pd;
    logic [6:0]  m_ps;
    logic [3:0]  m_shadow [4];
    bit   [3:0]  m_seen;
    bit          m_pend;
    logic [15:0] m_bcd;
    bit          m_fv;
    bit          m_err;
    bit          m_lost;
    int          m_since;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] decode_model(input logic [6:0] s);
        for (int v = 0; v < 10; v++) begin
            if (s == seg_of(v)) return 4'(v);
        end
        if (s == 7'b1111111) return 4'hA;
        return 4'hF;
    endfunction

    function automatic int slot_of(input logic [3:0] d);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (d == ~(4'b0001 << i)) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pd = 4'hF; m_ps = 7'h7F;
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'hA;
        m_seen = 4'b0000; m_pend = 0; m_bcd = 16'hAAAA;
        m_fv = 0; m_err = 0; m_lost = 1; m_since = 0;
    endtask

    // One clock edge of the model, seeing the inputs present at that edge
    task automatic model_edge(input logic [3:0] d, input logic [6:0] s);
        bit commit;
        int slot;
        commit = (m_run >= N) && !m_done;
        m_fv = 0;
        if (m_pend) begin
            m_bcd  = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
            m_err  = 0;
            for (int i = 0; i < 4; i++) if (m_shadow[i] == 4'hF) m_err = 1;
            m_fv   = 1;
            m_seen = 4'b0000;
            m_pend = 0;
        end
        if (commit) begin
            slot = slot_of(m_pd);
            m_shadow[slot] = decode_model(m_ps);
            m_seen[slot] = 1'b1;
            if (m_seen == 4'b1111) m_pend = 1;
            m_lost  = 0;
            m_since = 0;
        end else if (!m_lost) begin
            m_since++;
            if (m_since >= T) begin
                m_lost = 1;
                m_seen = 4'b0000;
                m_pend = 0;
            end
        end
        if (slot_of(d) >= 0 && d == m_pd && s == m_ps) begin
            m_run++;
            m_done = m_done || commit;
        end else begin
            m_run  = (slot_of(d) >= 0) ? 1 : 0;
            m_done = 0;
        end
        m_pd = d;
        m_ps = s;
    endtask

    // Hold one anode/segment pair for n edges, tracking DUT and model together
    task automatic step(input logic [3:0] d, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            DIGIT = d;
            DISPLAY = s;
            @(posedge clk);
            model_edge(d, s);
            #1;
            if (frame_valid === 1'b1) pulses++;
            if (m_fv) m_pulses++;
            if ({bcd_out, frame_valid, seg_err, scan_lost} !== {m_bcd, m_fv, m_err, m_lost}) begin
                if (cyc_err == 0)
                    first_diff = $sformatf("t=%0t dut=%h/%b/%b/%b model=%h/%b/%b/%b", $time,
                                           bcd_out, frame_valid, seg_err, scan_lost,
                                           m_bcd, m_fv, m_err, m_lost);
                cyc_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        DIGIT = 4'b1111;
        DISPLAY = 7'h7F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        pulses = 0; m_pulses = 0; cyc_err = 0; first_diff = "";
    endtask

    task automatic check_model(input string name);
        tests++;
        if (cyc_err !== 0) begin
            fails++;
            $display("FAIL %s model_agreement: %0d cycle diffs, required 0; first %s", name, cyc_err, first_diff);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (bcd_out !== 16'hAAAA) begin fails++; $display("FAIL reset_bcd: got %h, required AAAA", bcd_out); end
        tests++;
        if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_frame_valid: got %b, required 0", frame_valid); end
        tests++;
        if (seg_err !== 1'b0) begin fails++; $display("FAIL reset_seg_err: got %b, required 0", seg_err); end
        tests++;
        if (scan_lost !== 1'b1) begin fails++; $display("FAIL reset_scan_lost: got %b, required 1", scan_lost); end
        model_reset();
        rst = 1'b1;
        step(4'b1111, 7'h7F, 6);
        tests++;
        if (bcd_out !== 16'hAAAA || scan_lost !== 1'b1) begin
            fails++; $display("FAIL idle_after_reset: got %h/%b, required AAAA/1", bcd_out, scan_lost);
        end
    endtask

    task automatic test_basic_scan();
        do_reset();
        step(4'b1110, seg_of(4), 4);
        tests++;
        if (scan_lost !== 1'b1) begin fails++; $display("FAIL lost_before_commit: got %b, required 1", scan_lost); end
        step(4'b1110, seg_of(4), 1);
        tests++;
        if (scan_lost !== 1'b0) begin fails++; $display("FAIL lost_at_first_commit: got %b, required 0", scan_lost); end
        step(4'b1110, seg_of(4), 3);
        step(4'b1101, seg_of(3), 8);
        step(4'b1011, seg_of(2), 8);
        step(4'b0111, seg_of(1), 8);
        tests++;
        if (pulses !== 1) begin fails++; $display("FAIL basic_pulses: got %0d, required 1", pulses); end
        tests++;
        if (bcd_out !== 16'h1234) begin fails++; $display("FAIL basic_bcd: got %h, required 1234", bcd_out); end
        tests++;
        if (seg_err !== 1'b0) begin fails++; $display("FAIL basic_seg_err: got %b, required 0", seg_err); end
        check_model("basic");
    endtask

    task automatic test_short_dwell();
        do_reset();
        step(4'b1110, seg_of(4), 8);
        step(4'b1101, seg_of(3), 8);
        step(4'b1011, seg_of(2), 3);
        step(4'b0111, seg_of(1), 8);
        tests++;
        if (pulses !== 0 || bcd_out !== 16'hAAAA) begin
            fails++; $display("FAIL short_no_frame: got %0d pulses bcd %h, required 0 pulses bcd AAAA", pulses, bcd_out);
        end
        step(4'b1110, seg_of(4), 8);
        step(4'b1101, seg_of(3), 8);
        step(4'b1011, seg_of(2), 8);
        step(4'b0111, seg_of(1), 8);
        tests++;
        if (pulses !== 1 || bcd_out !== 16'h1234) begin
            fails++; $display("FAIL short_recover: got %0d pulses bcd %h, required 1 pulse bcd 1234", pulses, bcd_out);
        end
        check_model("short_dwell");
    endtask

    task automatic test_invalid_blank();
        do_reset();
        step(4'b1110, 7'b1111111, 8);
        step(4'b1101, seg_of(3), 8);
        step(4'b1011, 7'b1010101, 8);
        step(4'b0111, seg_of(1), 8);
        tests++;
        if (bcd_out !== 16'h1F3A) begin fails++; $display("FAIL invalid_bcd: got %h, required 1F3A", bcd_out); end
        tests++;
        if (seg_err !== 1'b1) begin fails++; $display("FAIL invalid_seg_err: got %b, required 1", seg_err); end
        check_model("invalid_blank");
    endtask

    task automatic test_timeout();
        do_reset();
        step(4'b1110, seg_of(4), 8);
        step(4'b1101, seg_of(3), 8);
        step(4'b1011, seg_of(2), 8);
        step(4'b0111, seg_of(1), 5);
        step(4'b1111, 7'h7F, T - 1);
        tests++;
        if (scan_lost !== 1'b0) begin fails++; $display("FAIL lost_early: got %b, required 0", scan_lost); end
        step(4'b1111, 7'h7F, 1);
        tests++;
        if (scan_lost !== 1'b1) begin fails++; $display("FAIL lost_at_timeout: got %b, required 1", scan_lost); end
        tests++;
        if (bcd_out !== 16'h1234 || seg_err !== 1'b0) begin
            fails++; $display("FAIL timeout_hold: got %h/%b, required 1234/0", bcd_out, seg_err);
        end
        step(4'b1110, seg_of(9), 4);
        tests++;
        if (scan_lost !== 1'b1) begin fails++; $display("FAIL resume_before_commit: got %b, required 1", scan_lost); end
        step(4'b1110, seg_of(9), 1);
        tests++;
        if (scan_lost !== 1'b0) begin fails++; $display("FAIL resume_commit: got %b, required 0", scan_lost); end
        check_model("timeout");
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(4'b1110, seg_of(8), 8);
        step(4'b1101, seg_of(7), 8);
        step(4'b1011, seg_of(6), 8);
        step(4'b0111, seg_of(5), 8);
        step(4'b1110, seg_of(4), 8);
        step(4'b1101, seg_of(3), 8);
        tests++;
        if (bcd_out !== 16'h5678) begin fails++; $display("FAIL pre_reset_bcd: got %h, required 5678", bcd_out); end
        check_model("pre_reset");
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bcd_out !== 16'hAAAA || scan_lost !== 1'b1) begin
            fails++; $display("FAIL async_reset: got %h/%b, required AAAA/1", bcd_out, scan_lost);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        pulses = 0; m_pulses = 0; cyc_err = 0;
        step(4'b1011, seg_of(2), 8);
        step(4'b0111, seg_of(1), 8);
        tests++;
        if (pulses !== 0) begin fails++; $display("FAIL partial_discarded: got %0d pulses, required 0", pulses); end
        step(4'b1110, seg_of(4), 8);
        step(4'b1101, seg_of(3), 8);
        tests++;
        if (pulses !== 1 || bcd_out !== 16'h1234) begin
            fails++; $display("FAIL post_reset_frame: got %0d pulses bcd %h, required 1 pulse bcd 1234", pulses, bcd_out);
        end
        check_model("reset_mid");
    endtask

    task automatic test_overwrite();
        do_reset();
        step(4'b1110, seg_of(5), 8);
        step(4'b1110, seg_of(7), 8);
        step(4'b1101, seg_of(3), 8);
        step(4'b1011, seg_of(2), 8);
        step(4'b0111, seg_of(1), 8);
        tests++;
        if (bcd_out !== 16'h1237 || pulses !== 1) begin
            fails++; $display("FAIL overwrite: got bcd %h pulses %0d, required 1237 and 1", bcd_out, pulses);
        end
        check_model("overwrite");
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(4'b1110, seg_of(4), 6);
        step(4'b1101, seg_of(3), 6);
        step(4'b1011, seg_of(2), 6);
        step(4'b0111, seg_of(1), 6);
        step(4'b1110, seg_of(5), 6);
        step(4'b1101, seg_of(6), 6);
        step(4'b1011, seg_of(7), 6);
        step(4'b0111, seg_of(8), 6);
        tests++;
        if (pulses !== 2 || bcd_out !== 16'h8765) begin
            fails++; $display("FAIL back_to_back: got %0d pulses bcd %h, required 2 pulses bcd 8765", pulses, bcd_out);
        end
        check_model("back_to_back");
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic [6:0] s;
        int len;
        do_reset();
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 99) < 85) d = ~(4'b0001 << $urandom_range(0, 3));
            else d = 4'($urandom);
            case ($urandom_range(0, 9))
                0:       s = 7'h7F;
                1, 2:    s = 7'($urandom);
                default: s = seg_of($urandom_range(0, 9));
            endcase
            len = ($urandom_range(0, 99) < 3) ? 60 : $urandom_range(1, 8);
            step(d, s, len);
        end
        tests++;
        if (pulses !== m_pulses) begin fails++; $display("FAIL random_pulses: got %0d, required %0d", pulses, m_pulses); end
        tests++;
        if (m_pulses < 1) begin fails++; $display("FAIL random_activity: got %0d frames, required at least 1", m_pulses); end
        check_model("random");
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_short_dwell();
        test_invalid_blank();
        test_timeout();
        test_reset_mid();
        test_overwrite();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
